// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Shadow records are sized for the largest supported geometry and zero-extended.
package pipe_pkg;

  localparam int REG_AW_MAX  = 8;
  localparam int NUM_SRC_MAX = 4;

  localparam int ST_IFID  = 1;
  localparam int ST_IDEX  = 2;
  localparam int ST_EXMEM = 3;
  localparam int ST_MEMWB = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                                   valid;
    logic [REG_AW_MAX-1:0]                  dst;
    logic                                   reg_write;
    logic                                   mem_read;
    logic [NUM_SRC_MAX-1:0][REG_AW_MAX-1:0] src;
    logic [NUM_SRC_MAX-1:0]                 src_used;
  } stage_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand EX forwarding select: EX/MEM ALU result beats MEM/WB write data,
// and register 0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_src_used,
  input  logic              i_exmem_valid,
  input  logic              i_exmem_reg_write,
  input  logic              i_exmem_mem_read,
  input  logic [REG_AW-1:0] i_exmem_dst,
  input  logic              i_memwb_valid,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_dst,
  output logic [1:0]        o_sel
);

  fwd_sel_e w_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_sel = FWD_RF;
    if (i_src_used && i_exmem_valid && i_exmem_reg_write && !i_exmem_mem_read &&
        (i_exmem_dst != '0) && (i_exmem_dst == i_src)) begin
      w_sel = FWD_EXMEM;
    end else if (i_src_used && i_memwb_valid && i_memwb_reg_write &&
                 (i_memwb_dst != '0) && (i_memwb_dst == i_src)) begin
      w_sel = FWD_MEMWB;
    end
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: load-use stalls, branch/jump flushes,
// EX forwarding selects, WB write qualifier and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,   // up to REG_AW_MAX
  parameter int NUM_SRC  = 2,   // up to NUM_SRC_MAX
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_jump,
  input  logic                      br_taken,
  output logic                      pc_hold,
  output logic                      ifid_hold,
  output logic [2:0]                flush_mask,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      wb_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam logic [2:0]       BR_MASK = 3'((1 << BR_STAGE) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t             r_stage [ST_IDEX:ST_MEMWB];
  stage_t             w_id_stage;
  logic [NUM_SRC-1:0] w_src_hit;
  logic               w_lu;
  logic               w_br;
  logic               w_jump;
  logic [2:0]         w_flush_mask;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  always_comb begin
    w_id_stage           = '0;
    w_id_stage.valid     = id_valid;
    w_id_stage.dst       = REG_AW_MAX'(id_dst);
    w_id_stage.reg_write = id_reg_write;
    w_id_stage.mem_read  = id_mem_read;
    w_src_hit            = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_id_stage.src[i]      = REG_AW_MAX'(id_src[i*REG_AW +: REG_AW]);
      w_id_stage.src_used[i] = id_src_used[i];
      w_src_hit[i]           = id_src_used[i] && (w_id_stage.src[i] == r_stage[ST_IDEX].dst);
    end
  end

  assign w_lu = id_valid && r_stage[ST_IDEX].valid && r_stage[ST_IDEX].mem_read &&
                (r_stage[ST_IDEX].dst != '0) && (|w_src_hit);
  assign w_br   = br_taken && r_stage[BR_STAGE].valid;
  assign w_jump = id_jump && id_valid && !w_lu && !w_br;

  // Branch squashes the stalled instruction too, so it overrides the hold.
  always_comb begin
    w_flush_mask = 3'b000;
    if (w_br) begin
      w_flush_mask = BR_MASK;
    end else if (w_lu) begin
      w_flush_mask[ST_IDEX-1] = 1'b1;
    end else if (w_jump) begin
      w_flush_mask[ST_IFID-1] = 1'b1;
    end
  end

  assign flush_mask = w_flush_mask;
  assign pc_hold    = w_lu && !w_br;
  assign ifid_hold  = w_lu && !w_br;
  assign wb_valid   = r_stage[ST_MEMWB].valid && r_stage[ST_MEMWB].reg_write &&
                      (r_stage[ST_MEMWB].dst != '0);
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only the valid bits matter, but clearing whole records keeps X out of the comparators.
      r_stage <= '{default: '0};
    end else begin
      // NOTE: non-blocking so every stage shifts from the pre-edge values.
      r_stage[ST_MEMWB] <= r_stage[ST_EXMEM];
      r_stage[ST_EXMEM] <= r_stage[ST_IDEX];
      r_stage[ST_IDEX]  <= w_id_stage;
      if (w_flush_mask[ST_IDEX-1])  r_stage[ST_IDEX].valid  <= 1'b0;
      if (w_flush_mask[ST_EXMEM-1]) r_stage[ST_EXMEM].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu && !w_br && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_br || w_jump) && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
      .i_src             (r_stage[ST_IDEX].src[i][REG_AW-1:0]),
      .i_src_used        (r_stage[ST_IDEX].src_used[i]),
      .i_exmem_valid     (r_stage[ST_EXMEM].valid),
      .i_exmem_reg_write (r_stage[ST_EXMEM].reg_write),
      .i_exmem_mem_read  (r_stage[ST_EXMEM].mem_read),
      .i_exmem_dst       (r_stage[ST_EXMEM].dst[REG_AW-1:0]),
      .i_memwb_valid     (r_stage[ST_MEMWB].valid),
      .i_memwb_reg_write (r_stage[ST_MEMWB].reg_write),
      .i_memwb_dst       (r_stage[ST_MEMWB].dst[REG_AW-1:0]),
      .o_sel             (fwd_sel[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (branch in EX/MEM with 16-bit counters,
// branch in ID/EX with 2-bit counters) against a per-instruction pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;

  typedef struct packed {
    logic                  v;
    logic [AW-1:0]         dst;
    logic                  rw;
    logic                  mr;
    logic [NS-1:0][AW-1:0] src;
    logic [NS-1:0]         used;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [NS*AW-1:0] id_src = '0;
  logic [NS-1:0]    id_src_used = '0;
  logic [AW-1:0]    id_dst = '0;
  logic             id_reg_write = 1'b0;
  logic             id_mem_read = 1'b0;
  logic             id_jump = 1'b0;
  logic             br_taken = 1'b0;

  logic             pc_hold, ifid_hold, wb_valid;
  logic [2:0]       flush_mask;
  logic [NS*2-1:0]  fwd_sel;
  logic [15:0]      stall_cnt, flush_cnt;
  logic             pc_hold2, ifid_hold2, wb_valid2;
  logic [2:0]       flush_mask2;
  logic [NS*2-1:0]  fwd_sel2;
  logic [1:0]       stall_cnt2, flush_cnt2;

  int n_vec = 0;
  int n_err = 0;

  rec_t ms [2][5];
  int   m_stall [2];
  int   m_flush [2];
  int   br_st [2] = '{3, 2};
  int   cmax  [2] = '{65535, 3};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .BR_STAGE(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_jump(id_jump), .br_taken(br_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .flush_mask(flush_mask),
    .fwd_sel(fwd_sel), .wb_valid(wb_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .BR_STAGE(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_jump(id_jump), .br_taken(br_taken),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .flush_mask(flush_mask2),
    .fwd_sel(fwd_sel2), .wb_valid(wb_valid2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_of(int k, int i);
    rec_t s2 = ms[k][2];
    rec_t s3 = ms[k][3];
    rec_t s4 = ms[k][4];
    if (!s2.used[i]) return 0;
    if (s3.v && s3.rw && !s3.mr && s3.dst != 0 && s3.dst == s2.src[i]) return 1;
    if (s4.v && s4.rw && s4.dst != 0 && s4.dst == s2.src[i]) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 5; s++) ms[k][s] = '0;
      m_stall[k] = 0;
      m_flush[k] = 0;
    end
  endtask

  // Check every output of both instances against the model, then advance the model
  // to match the coming clock edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      rec_t idr;
      bit   lu, br, jmp, wb;
      int   mask, efwd;
      lu = 0;
      if (id_valid && ms[k][2].v && ms[k][2].mr && ms[k][2].dst != 0)
        for (int i = 0; i < NS; i++)
          if (id_src_used[i] && id_src[i*AW +: AW] == ms[k][2].dst) lu = 1;
      br   = br_taken && ms[k][br_st[k]].v;
      jmp  = id_valid && id_jump && !lu && !br;
      mask = br ? ((1 << br_st[k]) - 1) : lu ? 2 : jmp ? 1 : 0;
      efwd = 0;
      for (int i = 0; i < NS; i++) efwd |= fwd_of(k, i) << (2 * i);
      wb = ms[k][4].v && ms[k][4].rw && ms[k][4].dst != 0;

      check($sformatf("u%0d flush_mask", k), k ? 32'(flush_mask2) : 32'(flush_mask), 32'(mask));
      check($sformatf("u%0d pc_hold", k),    k ? 32'(pc_hold2)    : 32'(pc_hold),    32'(lu && !br));
      check($sformatf("u%0d ifid_hold", k),  k ? 32'(ifid_hold2)  : 32'(ifid_hold),  32'(lu && !br));
      check($sformatf("u%0d fwd_sel", k),    k ? 32'(fwd_sel2)    : 32'(fwd_sel),    32'(efwd));
      check($sformatf("u%0d wb_valid", k),   k ? 32'(wb_valid2)   : 32'(wb_valid),   32'(wb));
      check($sformatf("u%0d stall_cnt", k),  k ? 32'(stall_cnt2)  : 32'(stall_cnt),  32'(m_stall[k]));
      check($sformatf("u%0d flush_cnt", k),  k ? 32'(flush_cnt2)  : 32'(flush_cnt),  32'(m_flush[k]));

      idr      = '0;
      idr.v    = id_valid;
      idr.dst  = id_dst;
      idr.rw   = id_reg_write;
      idr.mr   = id_mem_read;
      idr.src  = id_src;
      idr.used = id_src_used;
      ms[k][4] = ms[k][3];
      ms[k][3] = ms[k][2];
      if (mask & 4) ms[k][3].v = 1'b0;
      ms[k][2] = idr;
      if (mask & 2) ms[k][2].v = 1'b0;
      if (lu && !br && m_stall[k] < cmax[k]) m_stall[k]++;
      if ((br || jmp) && m_flush[k] < cmax[k]) m_flush[k]++;
    end
  endtask

  task automatic cyc(input bit v, input int s0, input int s1, input int used, input int dst,
                     input bit rw, input bit mr, input bit jmp, input bit br);
    id_valid     = v;
    id_src       = {AW'(s1), AW'(s0)};
    id_src_used  = NS'(used);
    id_dst       = AW'(dst);
    id_reg_write = rw;
    id_mem_read  = mr;
    id_jump      = jmp;
    br_taken     = br;
    #1;
  endtask

  task automatic fin();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    check("rst flush_mask", 32'(flush_mask), 32'd0);
    check("rst pc_hold",    32'(pc_hold),    32'd0);
    check("rst fwd_sel",    32'(fwd_sel),    32'd0);
    check("rst wb_valid",   32'(wb_valid),   32'd0);
    check("rst stall_cnt",  32'(stall_cnt),  32'd0);
    check("rst flush_cnt",  32'(flush_cnt),  32'd0);
    check("rst stall_cnt2", 32'(stall_cnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Load-use: lw r5 then add r6,r5,r1 -> exactly one stall, then MEM/WB forward.
    cyc(1, 2, 0, 1, 5, 1, 1, 0, 0); fin();
    cyc(1, 5, 1, 3, 6, 1, 0, 0, 0);
    check("lu pc_hold", 32'(pc_hold), 32'd1);
    check("lu flush_mask", 32'(flush_mask), 32'b010);
    fin();
    cyc(1, 5, 1, 3, 6, 1, 0, 0, 0);
    check("lu once", 32'(pc_hold), 32'd0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lu fwd memwb", 32'(fwd_sel), 32'b0010);
    check("lu stall_cnt", 32'(stall_cnt), 32'd1);
    fin();

    // Forward priority: r3 in both S3 and S4 -> EX/MEM; r0 destination -> none.
    cyc(1, 0, 0, 0, 3, 1, 0, 0, 0); fin();
    cyc(1, 0, 0, 0, 3, 1, 0, 0, 0); fin();
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0); fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("fwd exmem wins", 32'(fwd_sel[1:0]), 32'b01);
    fin();
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0); fin();
    cyc(1, 0, 0, 1, 4, 0, 0, 0, 0); fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("fwd r0", 32'(fwd_sel[1:0]), 32'b00);
    fin();

    // Branch flush with S3 valid, then a branch with S3 empty.
    cyc(1, 1, 2, 3, 7, 1, 0, 0, 0); fin();
    cyc(1, 1, 2, 3, 8, 1, 0, 0, 0); fin();
    cyc(1, 1, 2, 3, 9, 1, 0, 0, 1);
    check("br flush_mask", 32'(flush_mask), 32'b111);
    check("br pc_hold", 32'(pc_hold), 32'd0);
    fin();
    cyc(1, 1, 2, 3, 9, 1, 0, 0, 1);
    check("br s3 empty", 32'(flush_mask), 32'b000);
    check("br flush_cnt", 32'(flush_cnt), 32'd1);
    fin();

    // Branch + load-use + jump together, then jump with load-use.
    cyc(1, 1, 2, 3, 10, 1, 0, 0, 0); fin();
    cyc(1, 2, 0, 1, 7, 1, 1, 0, 0); fin();
    cyc(1, 7, 0, 1, 11, 1, 0, 1, 1);
    check("sim flush_mask", 32'(flush_mask), 32'b111);
    check("sim pc_hold", 32'(pc_hold), 32'd0);
    fin();
    cyc(1, 2, 0, 1, 9, 1, 1, 0, 0);
    check("sim stall_cnt", 32'(stall_cnt), 32'd1);
    check("sim flush_cnt", 32'(flush_cnt), 32'd2);
    fin();
    cyc(1, 9, 0, 1, 12, 1, 0, 1, 0);
    check("jlu flush_mask", 32'(flush_mask), 32'b010);
    check("jlu pc_hold", 32'(pc_hold), 32'd1);
    fin();
    cyc(1, 9, 0, 1, 12, 1, 0, 1, 0);
    check("jump flush_mask", 32'(flush_mask), 32'b001);
    fin();

    // Saturation of the 2-bit counter instance.
    for (int n = 0; n < 5; n++) begin
      cyc(1, 1, 0, 1, 5, 1, 1, 0, 0); fin();
      cyc(1, 0, 5, 2, 6, 1, 0, 0, 0); fin();
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat stall_cnt2", 32'(stall_cnt2), 32'd3);
    fin();

    // Reset while S2 holds a load: the next cycle must not stall.
    cyc(1, 0, 0, 0, 5, 1, 1, 0, 0); fin();
    do_reset();
    cyc(1, 5, 0, 1, 6, 1, 0, 0, 0);
    check("post-rst no stall", 32'(pc_hold), 32'd0);
    fin();

    // Randomized traffic on a small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 127) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 15);
        fin();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage RISC core (IF, ID, EX, MEM, WB).
- Keeps a shadow pipeline of per-stage {valid, dst, reg_write, mem_read, src tags} alongside the datapath's IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates load-use stalls, branch/jump flushes, EX-stage forwarding selects and a WB write qualifier.
- Generalises the core's fixed, hazard-free pipeline in register-address width, operand count, branch-resolve stage and counter width, and adds saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- BR_STAGE, 3, pipeline register holding a branch when br_taken asserts (2 = ID/EX, 3 = EX/MEM); legal values 2..3.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  ID source register addresses, operand 0 in LSBs
- id_src_used  in  NUM_SRC  per-operand "source actually read"
- id_dst  in  REG_AW  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- id_jump  in  1  ID instruction is an unconditional jump
- br_taken  in  1  branch in stage BR_STAGE resolved taken
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its value
- flush_mask  out  3  bit k-1 set: stage k (1 = IF/ID, 2 = ID/EX, 3 = EX/MEM) loads a bubble at the next edge
- fwd_sel  out  NUM_SRC*2  per EX operand: 00 = register file/ID/EX, 01 = EX/MEM ALU result, 10 = MEM/WB write data
- wb_valid  out  1  MEM/WB valid and reg_write and dst != 0
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  flush events, saturating

Behaviour:
- Reset (async, rst_n low):
  - All shadow valids = 0; counters = 0.
  - Combinational outputs therefore read 0 (fwd_sel = 00, flush_mask = 000).
- Shadow advance, each posedge:
  - S4 <- S3; S3 <- S2.
  - S2 <- ID fields with valid = id_valid, unless a bubble is inserted.
  - A bubble loads valid = 0 with the other fields don't-care.
- Load-use hazard, combinational. `lu` = 1 when all hold:
  - S2.valid and S2.mem_read;
  - S2.dst != 0;
  - for some i: id_src_used[i] and id_src[i] == S2.dst;
  - id_valid.
- On `lu`: pc_hold = ifid_hold = 1 and flush_mask[1] = 1 (bubble into ID/EX). Exactly one stall cycle per load-use pair.
- Branch taken:
  - br_taken is honoured only when S[BR_STAGE].valid = 1.
  - flush_mask bits 0..BR_STAGE-1 set: IF/ID, ID/EX and, if BR_STAGE = 3, EX/MEM bubble.
  - pc_hold = ifid_hold = 0.
  - Matching shadow stages are invalidated at the same edge.
- Jump: id_jump and id_valid and no `lu` and no branch -> flush_mask[0] = 1, one-bubble IF/ID squash.
- Priority: branch > load-use > jump.
  - A stall suppresses the jump; the jump re-evaluates next cycle.
  - A branch overrides the stall: the hold is dropped because the stalled instruction is squashed.
- Forwarding, per operand i, against S2.src[i] and S2.src_used[i]:
  - EX/MEM match: S3.valid, S3.reg_write, !S3.mem_read, S3.dst != 0, dst equal -> 01.
  - Else MEM/WB match: S4.valid, S4.reg_write, S4.dst != 0, dst equal -> 10.
  - Else 00.
  - EX/MEM wins over MEM/WB. Register 0 is never forwarded.
- Counters:
  - stall_cnt += 1 per cycle with `lu` and no branch.
  - flush_cnt += 1 per honoured branch or jump.
  - Both saturate at 2^CNT_W-1.
- Latency: all control outputs are combinational from current inputs and shadow state; shadow state updates 1 cycle later.
- Reset mid-stall or mid-flush: all state clears immediately; the first post-reset cycle behaves as an empty pipe.

Decomposition:
- Shared package `pipe_pkg`:
  - fwd_sel encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB);
  - stage index constants (ST_IFID = 1 .. ST_MEMWB = 4);
  - the shadow-stage record typedef {valid, dst, reg_write, mem_read, src, src_used}.
- One natural sub-module: `fwd_unit`, the per-operand forwarding comparator, instantiated NUM_SRC times.

Test Plan:
- Reset: rst_n low mid-run with S2 holding a load -> all outputs 0, counters 0, no stall on the next cycle.
- Load-use: lw r5 in S2; ID add r6,r5,r1 -> pc_hold = ifid_hold = 1 and flush_mask = 010 for exactly 1 cycle, then fwd_sel[op0] = 10 in EX; stall_cnt = 1.
- Forward priority: r3 written by both S3 (ALU) and S4 -> fwd_sel = 01. Destination r0 in S3 -> 00.
- Branch flush: BR_STAGE = 3, br_taken with S3.valid -> flush_mask = 111, shadow S2/S3 valid = 0 next edge, flush_cnt = 1. br_taken with S3.valid = 0 -> no effect.
- Simultaneous events:
  - br_taken with `lu` and id_jump -> flush_mask = 111, pc_hold = 0, stall_cnt unchanged, flush_cnt += 1.
  - id_jump with `lu` -> stall only; flush_mask = 001 on the following cycle.
- Saturation: CNT_W = 2, 5 consecutive load-use stalls -> stall_cnt stays 3.
